rtos_ctx_mem_arbiter: RTL and testbench
=======================================

Name: rtos_ctx_mem_arbiter

Overview:
- Shares one OBI-style data-memory master port between the core data port and NUM_CH RTOS context-unit memory channels.
- Each context channel has three valid/ready interfaces: write, read-address and read-data.
- Sits between the core, the context unit(s) and data memory in the next-generation simulation/integration top, replacing the unconnected context-memory channels.
- Tracks up to MAX_OUTST in-flight transactions so that each response is routed back to the source that issued it.

Parameters:
- NUM_CH, 1, number of context-unit memory channels (1..8)
- AW, 32, address width
- DW, 32, data width
- MAX_OUTST, 2, depth of the route FIFO (maximum in-flight memory transactions, power of 2)
- STARVE_LIMIT, 8, consecutive lost cycles before the starvation guard fires (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- core_req_i / core_gnt_o / core_rvalid_o  in/out/out  1  core OBI slave handshake
- core_we_i  in  1  core write enable
- core_be_i  in  DW/8  core byte enables
- core_addr_i  in  AW  core address
- core_wdata_i  in  DW  core write data
- core_rdata_o  out  DW  core read data
- ctx_wr_valid_i / ctx_wr_ready_o  in/out  NUM_CH  per-channel write handshake
- ctx_wr_addr_i  in  NUM_CH*AW  write addresses, channel c in slice [c*AW +: AW]
- ctx_wr_data_i  in  NUM_CH*DW  write data
- ctx_rd_addr_valid_i / ctx_rd_addr_ready_o  in/out  NUM_CH  read-address handshake
- ctx_rd_addr_i  in  NUM_CH*AW  read addresses
- ctx_rd_data_valid_o / ctx_rd_data_ready_i  out/in  NUM_CH  read-data handshake
- ctx_rd_data_o  out  NUM_CH*DW  read data
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1  memory master handshake
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DW/8  memory byte enables
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - Route FIFO empty, RR pointer 0, lock clear, read buffers empty, err_o 0.
  - All valid, ready, gnt and req outputs 0.
  - ctx_rd_data_o is 0.
  - mem_* payload outputs are 0 when mem_req_o is 0.
- Eligibility:
  - Core is eligible when core_req_i=1.
  - Channel c is write-eligible when ctx_wr_valid_i[c]=1.
  - Channel c is read-eligible when ctx_rd_addr_valid_i[c]=1, its read buffer is empty and it has no read in flight. Each channel has at most one read outstanding.
  - Within a channel, a write takes precedence over a read.
- Arbitration:
  - The core has fixed highest priority.
  - Context channels arbitrate round-robin starting at the RR pointer.
  - After a context grant the pointer becomes (granted channel + 1) mod NUM_CH.
- Request issue:
  - mem_req_o=1 only if some source is eligible and the route FIFO is not full.
  - The payload comes combinationally from the selected source.
  - Context writes drive mem_be_o all ones.
  - Context reads drive mem_we_o=0.
- Lock (OBI stability):
  - If mem_req_o=1 and mem_gnt_i=0, the selected source and operation are registered.
  - The locked source is held until granted, even if the core requests meanwhile.
  - The lock clears on gnt.
- On mem_gnt_i=1 in the same cycle as mem_req_o=1:
  - Assert the granting source's core_gnt_o, ctx_wr_ready_o[c] or ctx_rd_addr_ready_o[c] combinationally.
  - Push {src, is_write} into the route FIFO.
  - Sources must hold valid and payload until they see ready/gnt.
- Response (mem_rvalid_i=1):
  - Pop the FIFO head.
  - If src=core: core_rvalid_o=1 and core_rdata_o=mem_rdata_i in the same cycle. core_rdata_o passes through mem_rdata_i at all times.
  - If ctx write: the response is discarded.
  - If ctx read: mem_rdata_i is captured into channel c's buffer, and ctx_rd_data_valid_o[c]=1 from the next cycle until ctx_rd_data_ready_i[c].
- Simultaneous push and pop: allowed, and the FIFO count is unchanged. A push while full is impossible because req is gated when full.
- If mem_rvalid_i=1 with the FIFO empty: set err_o (sticky until reset) and ignore the response.
- Latency:
  - A context read with zero-wait memory delivers ctx_rd_data_valid_o 2 cycles after the address handshake.
  - A core request adds no cycles.
- Reset mid-operation: all in-flight state is dropped. The memory subsystem must be reset together with this block.

Optional Feature:
- Macro: RTOS_CTX_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments each cycle a context channel is eligible but the core is selected.
  - The counter clears on any context grant.
  - When the counter reaches STARVE_LIMIT, the next arbitration (when not locked) selects the RR context winner over the core.
  - The counter saturates at STARVE_LIMIT.
- Without the macro: the core always wins, and no counter exists.

Test Plan:
- Core only, zero-wait memory, 4 alternating reads and writes to 0x100 through 0x10C: core_gnt_o follows mem_gnt_i, core_rvalid_o arrives 1 cycle later, rdata passes through, ctx outputs stay 0.
- NUM_CH=2, both channels write-valid continuously, core idle: grants alternate ch0, ch1, ch0, ch1, and each ctx_wr_ready_o pulses for 1 cycle.
- Ch0 issues a read of 0x200 while memory returns 0xDEADBEEF and ctx_rd_data_ready_i[0] is held 0 for 3 cycles: ctx_rd_data_valid_o[0] is held with 0xDEADBEEF, and a second ch0 read is not issued until the buffer drains.
- Ch1 request stalled with mem_gnt_i=0 for 3 cycles while core_req_i rises in cycle 2: mem_addr_o stays at the ch1 address, ch1 is granted first, and the core is granted the following cycle.
- MAX_OUTST=2 with 2 reads granted and no rvalid: mem_req_o drops to 0. Then a spurious third mem_rvalid_i with the FIFO empty sets err_o=1, which holds until rst_ni=0 is sampled.
- With RTOS_CTX_STARVE_GUARD_EN and STARVE_LIMIT=8, core_req_i held 1 while ch0 write-valid: ch0 is granted exactly after 8 cycles of core grants, and without the macro ch0 is never granted.

Source files
------------

// File: rtl/rtos_ctx_mem_arbiter.sv
// rtos_ctx_mem_arbiter: shares one OBI data-memory master port between the core data port
//   (fixed highest priority) and NUM_CH round-robin RTOS context-unit memory channels.
// Latency: requests and grants are combinational, so the core path adds no cycles.
//   A context read presents its data 2 cycles after the address handshake with zero-wait memory.
// Backpressure: mem_req is withheld while the route FIFO holds MAX_OUTST in-flight transactions.
//   A request that is not granted is locked to its source until mem_gnt arrives.
//   Each channel read buffer stalls further reads on that channel until ctx_rd_data_ready drains it.
// Ports:
//   clk_i, rst_ni                    : clock and synchronous active-low reset
//   core_*                           : OBI slave port towards the core data interface
//   ctx_wr_* / ctx_rd_addr_*         : per-channel valid/ready request interfaces
//   ctx_rd_data_*                    : per-channel read-data interfaces; channel c uses slice [c*W +: W]
//   mem_*                            : OBI master port towards data memory
//   err_o                            : sticky flag for a response that arrives with nothing in flight
// Optional: define RTOS_CTX_STARVE_GUARD_EN to let a starved context channel beat the core
//   after STARVE_LIMIT consecutive lost cycles.

// Generic synchronous FIFO, used here to track which source owns each in-flight transaction.
module rtos_ctx_route_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end
endmodule

module rtos_ctx_mem_arbiter #(
  parameter int NUM_CH       = 1,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // core OBI slave
  input  logic                 core_req_i,
  output logic                 core_gnt_o,
  output logic                 core_rvalid_o,
  input  logic                 core_we_i,
  input  logic [DW/8-1:0]      core_be_i,
  input  logic [AW-1:0]        core_addr_i,
  input  logic [DW-1:0]        core_wdata_i,
  output logic [DW-1:0]        core_rdata_o,
  // context channels
  input  logic [NUM_CH-1:0]    ctx_wr_valid_i,
  output logic [NUM_CH-1:0]    ctx_wr_ready_o,
  input  logic [NUM_CH*AW-1:0] ctx_wr_addr_i,
  input  logic [NUM_CH*DW-1:0] ctx_wr_data_i,
  input  logic [NUM_CH-1:0]    ctx_rd_addr_valid_i,
  output logic [NUM_CH-1:0]    ctx_rd_addr_ready_o,
  input  logic [NUM_CH*AW-1:0] ctx_rd_addr_i,
  output logic [NUM_CH-1:0]    ctx_rd_data_valid_o,
  input  logic [NUM_CH-1:0]    ctx_rd_data_ready_i,
  output logic [NUM_CH*DW-1:0] ctx_rd_data_o,
  // memory OBI master
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  output logic                 mem_we_o,
  output logic [DW/8-1:0]      mem_be_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic [DW-1:0]        mem_rdata_i,
  output logic                 err_o
);
  // Source encoding: 0 is the core, c+1 is context channel c.
  localparam int SRC_W = $clog2(NUM_CH + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RT_W  = SRC_W + 1;

  typedef logic [SRC_W-1:0] src_t;
  typedef struct packed {
    src_t src;
    logic is_write;
  } route_t;

  logic [NUM_CH-1:0]    rd_buf_vld;
  logic [NUM_CH-1:0]    rd_inflight;
  logic [NUM_CH-1:0]    rd_elig;
  logic [NUM_CH-1:0]    ctx_elig;
  logic [NUM_CH*DW-1:0] rd_buf_dat;

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] rr_ch;
  logic [CH_W-1:0] sel_ch;
  logic [CH_W-1:0] next_ptr;
  logic            rr_found;

  logic locked;
  logic lock_wr;
  src_t lock_src;

  src_t sel_src;
  logic sel_wr;
  logic sel_any;
  logic sel_core;

  logic   fire;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  route_t push_ent;
  route_t head;
  logic   err_q;
  logic   starve_fire;

  // A channel may only have one read outstanding, and not while its buffer still holds data.
  assign rd_elig  = ctx_rd_addr_valid_i & ~rd_buf_vld & ~rd_inflight;
  assign ctx_elig = ctx_wr_valid_i | rd_elig;

  // Round-robin search over the context channels, starting at rr_ptr.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!rr_found && ctx_elig[idx]) begin
        rr_found = 1'b1;
        rr_ch    = CH_W'(idx);
      end
    end
  end

  // Source selection: a locked request always wins so the OBI payload stays stable.
  always_comb begin
    sel_src = '0;
    sel_wr  = 1'b0;
    sel_any = 1'b0;
    if (locked) begin
      sel_src = lock_src;
      sel_wr  = lock_wr;
      sel_any = 1'b1;
    end else if (core_req_i && !(starve_fire && rr_found)) begin
      sel_src = '0;
      sel_wr  = core_we_i;
      sel_any = 1'b1;
    end else if (rr_found) begin
      sel_src = src_t'(rr_ch) + src_t'(1);
      sel_wr  = ctx_wr_valid_i[rr_ch];
      sel_any = 1'b1;
    end
  end

  always_comb begin
    sel_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_src == src_t'(c + 1)) sel_ch = CH_W'(c);
    end
  end

  assign sel_core  = (sel_src == '0);
  assign mem_req_o = rst_ni && sel_any && !fifo_full;
  assign fire      = mem_req_o && mem_gnt_i;
  assign pop       = mem_rvalid_i && !fifo_empty;
  assign next_ptr  = (sel_ch == CH_W'(NUM_CH - 1)) ? '0 : sel_ch + CH_W'(1);

  // Payload mux, forced to zero whenever no request is presented.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel_core) begin
        mem_we_o    = core_we_i;
        mem_be_o    = core_be_i;
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
      end else begin
        mem_we_o = sel_wr;
        mem_be_o = '1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (sel_ch == CH_W'(c)) begin
            mem_addr_o  = sel_wr ? ctx_wr_addr_i[c*AW +: AW] : ctx_rd_addr_i[c*AW +: AW];
            mem_wdata_o = sel_wr ? ctx_wr_data_i[c*DW +: DW] : '0;
          end
        end
      end
    end
  end

  // Grants back to the sources are combinational on mem_gnt.
  always_comb begin
    ctx_wr_ready_o      = '0;
    ctx_rd_addr_ready_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (fire && !sel_core && sel_ch == CH_W'(c)) begin
        if (sel_wr) ctx_wr_ready_o[c] = 1'b1;
        else        ctx_rd_addr_ready_o[c] = 1'b1;
      end
    end
  end

  assign core_gnt_o    = fire && sel_core;
  assign core_rvalid_o = pop && (head.src == '0);
  assign core_rdata_o  = mem_rdata_i;

  assign push_ent.src      = sel_src;
  assign push_ent.is_write = sel_wr;

  rtos_ctx_route_fifo #(
    .WIDTH (RT_W),
    .DEPTH (MAX_OUTST)
  ) u_route_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (fire),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      locked      <= 1'b0;
      lock_src    <= '0;
      lock_wr     <= 1'b0;
      rr_ptr      <= '0;
      err_q       <= 1'b0;
      rd_buf_vld  <= '0;
      rd_inflight <= '0;
      rd_buf_dat  <= '0;
    end else begin
      if (mem_req_o && !mem_gnt_i) begin
        locked   <= 1'b1;
        lock_src <= sel_src;
        lock_wr  <= sel_wr;
      end else if (fire) begin
        locked <= 1'b0;
      end

      if (fire && !sel_core) rr_ptr <= next_ptr;

      if (mem_rvalid_i && fifo_empty) err_q <= 1'b1;

      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_buf_vld[c] && ctx_rd_data_ready_i[c]) rd_buf_vld[c] <= 1'b0;
        if (fire && !sel_core && !sel_wr && sel_ch == CH_W'(c)) rd_inflight[c] <= 1'b1;
        // Context write responses carry nothing useful and are simply dropped.
        if (pop && head.src == src_t'(c + 1) && !head.is_write) begin
          rd_inflight[c]         <= 1'b0;
          rd_buf_vld[c]          <= 1'b1;
          rd_buf_dat[c*DW +: DW] <= mem_rdata_i;
        end
      end
    end
  end

  assign ctx_rd_data_valid_o = rd_buf_vld;
  assign ctx_rd_data_o       = rd_buf_dat;
  assign err_o               = err_q;

`ifdef RTOS_CTX_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  assign starve_fire = (starve_cnt == SC_W'(STARVE_LIMIT));

  // Counts cycles a context channel waited while the core took the port; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (fire && !sel_core) begin
      starve_cnt <= '0;
    end else if ((|ctx_elig) && mem_req_o && sel_core && !starve_fire) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end
`else
  assign starve_fire = 1'b0;
`endif
endmodule

// File: tb/tb_rtos_ctx_mem_arbiter.sv
// tb_rtos_ctx_mem_arbiter: directed bench for the context-memory arbiter with two channels.
// Latency: inputs change 1 time unit after the rising edge and outputs are sampled 3 units later.
// Backpressure: memory grant/rvalid and read-data ready are driven directly by each vector.
module tb_rtos_ctx_mem_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk;
  logic              rst_ni;
  logic              core_req, core_gnt, core_rvalid, core_we;
  logic [DW/8-1:0]   core_be;
  logic [AW-1:0]     core_addr;
  logic [DW-1:0]     core_wdata, core_rdata;
  logic [NCH-1:0]    ctx_wr_valid, ctx_wr_ready;
  logic [NCH*AW-1:0] ctx_wr_addr;
  logic [NCH*DW-1:0] ctx_wr_data;
  logic [NCH-1:0]    ctx_rd_addr_valid, ctx_rd_addr_ready;
  logic [NCH*AW-1:0] ctx_rd_addr;
  logic [NCH-1:0]    ctx_rd_data_valid, ctx_rd_data_ready;
  logic [NCH*DW-1:0] ctx_rd_data;
  logic              mem_req, mem_gnt, mem_rvalid, mem_we;
  logic [DW/8-1:0]   mem_be;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              err;

  int n_chk;
  int n_fail;
  int first_gnt;
  int n_ctx;
  int n_core;

  rtos_ctx_mem_arbiter #(
    .NUM_CH       (NCH),
    .AW           (AW),
    .DW           (DW),
    .MAX_OUTST    (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .core_req_i          (core_req),
    .core_gnt_o          (core_gnt),
    .core_rvalid_o       (core_rvalid),
    .core_we_i           (core_we),
    .core_be_i           (core_be),
    .core_addr_i         (core_addr),
    .core_wdata_i        (core_wdata),
    .core_rdata_o        (core_rdata),
    .ctx_wr_valid_i      (ctx_wr_valid),
    .ctx_wr_ready_o      (ctx_wr_ready),
    .ctx_wr_addr_i       (ctx_wr_addr),
    .ctx_wr_data_i       (ctx_wr_data),
    .ctx_rd_addr_valid_i (ctx_rd_addr_valid),
    .ctx_rd_addr_ready_o (ctx_rd_addr_ready),
    .ctx_rd_addr_i       (ctx_rd_addr),
    .ctx_rd_data_valid_o (ctx_rd_data_valid),
    .ctx_rd_data_ready_i (ctx_rd_data_ready),
    .ctx_rd_data_o       (ctx_rd_data),
    .mem_req_o           (mem_req),
    .mem_gnt_i           (mem_gnt),
    .mem_rvalid_i        (mem_rvalid),
    .mem_we_o            (mem_we),
    .mem_be_o            (mem_be),
    .mem_addr_o          (mem_addr),
    .mem_wdata_o         (mem_wdata),
    .mem_rdata_i         (mem_rdata),
    .err_o               (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req          = 1'b0;
    core_we           = 1'b0;
    core_be           = '0;
    core_addr         = '0;
    core_wdata        = '0;
    ctx_wr_valid      = '0;
    ctx_wr_addr       = '0;
    ctx_wr_data       = '0;
    ctx_rd_addr_valid = '0;
    ctx_rd_addr       = '0;
    ctx_rd_data_ready = '0;
    mem_gnt           = 1'b0;
    mem_rvalid        = 1'b0;
    mem_rdata         = '0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rst_ni = 1'b0;
    tick();

    // Reset: outputs must be quiet even with a request pending.
    core_req = 1'b1;
    mem_gnt  = 1'b1;
    tick();
    #3;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_core_gnt", 64'(core_gnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_valid", 64'(ctx_rd_data_valid), 64'd0);
    check("rst_rd_data", 64'(ctx_rd_data), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    tick();
    rst_ni = 1'b1;

    // Core only, zero-wait memory, alternating reads/writes.
    for (int k = 0; k < 5; k++) begin
      idle();
      core_req   = (k < 4);
      core_we    = (k % 2 == 1);
      core_be    = core_we ? 4'h3 : 4'hF;
      core_addr  = 32'(32'h100 + 4 * k);
      core_wdata = 32'(32'hA000 + k);
      mem_gnt    = 1'b1;
      mem_rvalid = (k >= 1);
      mem_rdata  = 32'(32'h5000 + k);
      #3;
      if (k < 4) begin
        check("core_req", 64'(mem_req), 64'd1);
        check("core_addr", 64'(mem_addr), 64'(32'h100 + 4 * k));
        check("core_we", 64'(mem_we), 64'(k % 2 == 1));
        check("core_be", 64'(mem_be), (k % 2 == 1) ? 64'h3 : 64'hF);
        check("core_wdata", 64'(mem_wdata), 64'(32'hA000 + k));
        check("core_gnt", 64'(core_gnt), 64'd1);
      end else begin
        check("core_req_end", 64'(mem_req), 64'd0);
        check("core_gnt_end", 64'(core_gnt), 64'd0);
        check("core_addr_end", 64'(mem_addr), 64'd0);
      end
      check("core_rvalid", 64'(core_rvalid), 64'(k >= 1));
      if (k >= 1) check("core_rdata", 64'(core_rdata), 64'(32'h5000 + k));
      check("core_ctx_quiet", 64'({ctx_wr_ready, ctx_rd_addr_ready, ctx_rd_data_valid}), 64'd0);
      tick();
    end

    // Two channels writing continuously: round-robin alternation.
    for (int k = 0; k < 5; k++) begin
      idle();
      ctx_wr_valid = (k < 4) ? 2'b11 : 2'b00;
      ctx_wr_addr  = {32'h1100, 32'h1000};
      ctx_wr_data  = {32'hB1, 32'hB0};
      mem_gnt      = 1'b1;
      mem_rvalid   = (k >= 1);
      #3;
      if (k < 4) begin
        check("rr_ready", 64'(ctx_wr_ready), (k % 2 == 1) ? 64'b10 : 64'b01);
        check("rr_addr", 64'(mem_addr), (k % 2 == 1) ? 64'h1100 : 64'h1000);
        check("rr_wdata", 64'(mem_wdata), (k % 2 == 1) ? 64'hB1 : 64'hB0);
        check("rr_be_we", 64'({mem_be, mem_we}), 64'h1F);
      end else begin
        check("rr_req_end", 64'(mem_req), 64'd0);
      end
      check("rr_no_core_rvalid", 64'(core_rvalid), 64'd0);
      tick();
    end

    // Channel 0 read with a stalled consumer; second read waits for the buffer.
    idle();
    ctx_rd_addr_valid = 2'b01;
    ctx_rd_addr[31:0] = 32'h200;
    mem_gnt = 1'b1;
    #3;
    check("rd_req", 64'(mem_req), 64'd1);
    check("rd_addr", 64'(mem_addr), 64'h200);
    check("rd_we", 64'(mem_we), 64'd0);
    check("rd_addr_ready", 64'(ctx_rd_addr_ready), 64'b01);
    tick();
    idle();
    ctx_rd_addr_valid = 2'b01;
    ctx_rd_addr[31:0] = 32'h204;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    #3;
    check("rd_inflight_req", 64'(mem_req), 64'd0);
    check("rd_lat_valid", 64'(ctx_rd_data_valid), 64'd0);
    check("rd_core_rvalid", 64'(core_rvalid), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      ctx_rd_addr_valid = 2'b01;
      ctx_rd_addr[31:0] = 32'h204;
      mem_gnt = 1'b1;
      ctx_rd_data_ready = (k == 3) ? 2'b01 : 2'b00;
      #3;
      check("rd_hold_valid", 64'(ctx_rd_data_valid), 64'b01);
      check("rd_hold_data", 64'(ctx_rd_data[31:0]), 64'hDEADBEEF);
      check("rd_blocked", 64'(mem_req), 64'd0);
      tick();
    end
    idle();
    ctx_rd_addr_valid = 2'b01;
    ctx_rd_addr[31:0] = 32'h204;
    mem_gnt = 1'b1;
    #3;
    check("rd2_drained", 64'(ctx_rd_data_valid), 64'd0);
    check("rd2_req", 64'(mem_req), 64'd1);
    check("rd2_addr", 64'(mem_addr), 64'h204);
    check("rd2_ready", 64'(ctx_rd_addr_ready), 64'b01);
    tick();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    #3;
    check("rd2_lat", 64'(ctx_rd_data_valid), 64'd0);
    tick();
    idle();
    ctx_rd_data_ready = 2'b01;
    #3;
    check("rd2_valid", 64'(ctx_rd_data_valid), 64'b01);
    check("rd2_data", 64'(ctx_rd_data[31:0]), 64'h12345678);
    tick();
    idle();
    #3;
    check("rd2_gone", 64'(ctx_rd_data_valid), 64'd0);
    tick();

    // Channel 1 stalled by memory; the core arrives mid-stall and must wait.
    for (int k = 0; k < 4; k++) begin
      idle();
      ctx_wr_valid = 2'b10;
      ctx_wr_addr[63:32] = 32'h300;
      ctx_wr_data[63:32] = 32'h33;
      core_req  = (k >= 2);
      core_addr = 32'h400;
      mem_gnt   = (k == 3);
      #3;
      check("lock_req", 64'(mem_req), 64'd1);
      check("lock_addr", 64'(mem_addr), 64'h300);
      check("lock_core_gnt", 64'(core_gnt), 64'd0);
      check("lock_ready", 64'(ctx_wr_ready), (k == 3) ? 64'b10 : 64'b00);
      tick();
    end
    idle();
    core_req   = 1'b1;
    core_addr  = 32'h400;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    #3;
    check("lock_then_core_gnt", 64'(core_gnt), 64'd1);
    check("lock_then_core_addr", 64'(mem_addr), 64'h400);
    check("lock_wr_resp_dropped", 64'(core_rvalid), 64'd0);
    tick();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    #3;
    check("lock_core_rvalid", 64'(core_rvalid), 64'd1);
    check("lock_core_rdata", 64'(core_rdata), 64'h77);
    tick();

    // Route FIFO full: request gated. Then a spurious response sets err.
    for (int k = 0; k < 3; k++) begin
      idle();
      ctx_rd_addr_valid = 2'b11;
      ctx_rd_addr = {32'h600, 32'h500};
      core_req  = (k == 2);
      core_addr = 32'h900;
      mem_gnt   = 1'b1;
      #3;
      if (k == 0) begin
        check("full_ready0", 64'(ctx_rd_addr_ready), 64'b01);
        check("full_addr0", 64'(mem_addr), 64'h500);
      end else if (k == 1) begin
        check("full_ready1", 64'(ctx_rd_addr_ready), 64'b10);
        check("full_addr1", 64'(mem_addr), 64'h600);
      end else begin
        check("full_req_gated", 64'(mem_req), 64'd0);
        check("full_core_gnt", 64'(core_gnt), 64'd0);
      end
      tick();
    end
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111;
    #3;
    check("full_pop0_core", 64'(core_rvalid), 64'd0);
    check("full_pop0_valid", 64'(ctx_rd_data_valid), 64'd0);
    tick();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h2222;
    ctx_rd_data_ready = 2'b11;
    #3;
    check("full_ch0_valid", 64'(ctx_rd_data_valid), 64'b01);
    check("full_ch0_data", 64'(ctx_rd_data[31:0]), 64'h1111);
    tick();
    idle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h3333;
    ctx_rd_data_ready = 2'b11;
    #3;
    check("full_ch1_valid", 64'(ctx_rd_data_valid), 64'b10);
    check("full_ch1_data", 64'(ctx_rd_data[63:32]), 64'h2222);
    check("spur_err_before", 64'(err), 64'd0);
    check("spur_no_rvalid", 64'(core_rvalid), 64'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      idle();
      #3;
      check("spur_err_sticky", 64'(err), 64'd1);
      tick();
    end
    idle();
    rst_ni = 1'b0;
    #3;
    check("spur_err_until_edge", 64'(err), 64'd1);
    tick();
    #3;
    check("spur_err_cleared", 64'(err), 64'd0);
    tick();
    rst_ni = 1'b1;
    #3;
    check("post_rst_err", 64'(err), 64'd0);
    tick();

    // Core held busy while channel 0 wants to write.
    first_gnt = 999;
    n_ctx     = 0;
    n_core    = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      core_req = 1'b1;
      core_addr = 32'h700;
      ctx_wr_valid = 2'b01;
      ctx_wr_addr[31:0] = 32'h800;
      mem_gnt    = 1'b1;
      mem_rvalid = (k >= 1);
      #3;
      if (ctx_wr_ready[0]) begin
        n_ctx++;
        if (first_gnt == 999) first_gnt = k;
      end
      if (core_gnt) n_core++;
      tick();
    end
`ifdef RTOS_CTX_STARVE_GUARD_EN
    check("starve_first", 64'(first_gnt), 64'd8);
    check("starve_ctx_cnt", 64'(n_ctx), 64'd2);
    check("starve_core_cnt", 64'(n_core), 64'd18);
`else
    check("starve_first", 64'(first_gnt), 64'd999);
    check("starve_ctx_cnt", 64'(n_ctx), 64'd0);
    check("starve_core_cnt", 64'(n_core), 64'd20);
`endif
    idle();
    mem_rvalid = 1'b1;
    tick();
    idle();
    #3;
    check("final_err", 64'(err), 64'd0);
    check("final_req", 64'(mem_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
